// File: rtl/robotron_sound_cmd_sched_if.sv
// Requester-side handshake bundle for the sound-command scheduler.
// Slice i of req_cmd is {hand_bit, code[5:0]} for requester i.
interface robotron_sound_cmd_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [7*N_REQ-1:0] req_cmd;
    logic [N_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_cmd,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        output req_ready
    );
endinterface

// File: rtl/robotron_sound_cmd_sched.sv
// Round-robin sound-command scheduler: drives the active-low pb/hand
// lines of robotron_sound with a fixed hold followed by a release gap.
module robotron_sound_cmd_sched #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 64,
    parameter int GAP_CYCLES  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    robotron_sound_cmd_sched_if.slave req,
    output logic [5:0]                pb_out,
    output logic                      hand_out,
    output logic                      busy,
    output logic [2:0]                grant_id
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                          HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [2:0]    LAST_ID = 3'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_GAP
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [2:0]     grant_q, grant_d;
    logic [5:0]     pb_q, pb_d;
    logic           hand_q, hand_d;

    logic [7:0]     valid_pad;
    logic [6:0]     cmd_arr [8];
    logic           win_found;
    logic [2:0]     win_id;
    logic [3:0]     idx;
    logic [6:0]     win_cmd;
    logic           accept;
    logic           noop;

    // Pad requester vectors to 8 so a 3-bit index is always in range.
    always_comb begin
        valid_pad = '0;
        for (int i = 0; i < 8; i++) begin
            cmd_arr[i] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            valid_pad[i] = req.req_valid[i];
            cmd_arr[i]   = req.req_cmd[7*i +: 7];
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(N_REQ)) begin
                idx = idx - 4'(N_REQ);
            end
            if (!win_found && valid_pad[idx[2:0]]) begin
                win_found = 1'b1;
                win_id    = idx[2:0];
            end
        end
    end

    assign win_cmd = cmd_arr[win_id];
    assign accept  = (state_q == S_IDLE) && win_found && !reset;
    assign noop    = (win_cmd == 7'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            pb_q    <= '1;
            hand_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            pb_q    <= pb_d;
            hand_q  <= hand_d;
        end
    end

    // Output levels are computed with the next state so they are registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        pb_d    = pb_q;
        hand_d  = hand_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d = win_id;
                    ptr_d   = (win_id == LAST_ID) ?
                              3'd0 : win_id + 3'd1;
                    if (!noop) begin
                        state_d = S_ASSERT;
                        cnt_d   = HOLD_LD;
                        pb_d    = ~win_cmd[5:0];
                        hand_d  = ~win_cmd[6];
                    end
                end
            end
            S_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                    pb_d    = '1;
                    hand_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req.req_ready = '0;
        if (accept) begin
            req.req_ready[win_id] = 1'b1;
        end
        busy     = (state_q != S_IDLE);
        pb_out   = pb_q;
        hand_out = hand_q;
        grant_id = grant_q;
    end
endmodule

// File: tb/tb_robotron_sound_cmd_sched.sv
// Directed bench for robotron_sound_cmd_sched (N_REQ=4, HOLD=64, GAP=32).
// Expected values are hand-derived constants checked with immediate asserts.
module tb_robotron_sound_cmd_sched;
    logic       clk;
    logic       reset;
    logic [5:0] pb_out;
    logic       hand_out;
    logic       busy;
    logic [2:0] grant_id;
    int         checks;
    int         failures;
    logic [2:0] e;

    robotron_sound_cmd_sched_if #(.N_REQ(4)) rif ();

    robotron_sound_cmd_sched #(
        .N_REQ      (4),
        .HOLD_CYCLES(64),
        .GAP_CYCLES (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (rif),
        .pb_out  (pb_out),
        .hand_out(hand_out),
        .busy    (busy),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        rif.req_valid = '0;
        rif.req_cmd   = '0;

        // Reset state
        repeat (10) step();
        reset = 1'b0;
        check("rst_pb", 32'(pb_out), 32'h3f);
        check("rst_hand", 32'(hand_out), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(rif.req_ready), 32'h0);
        check("rst_gid", 32'(grant_id), 32'h0);

        // Single request: code 000011, hand bit set
        rif.req_valid = 4'b0001;
        rif.req_cmd[6:0] = 7'b1000011;
        #1;
        check("single_ready", 32'(rif.req_ready), 32'h1);
        step();
        rif.req_valid = '0;
        check("single_ready_off", 32'(rif.req_ready), 32'h0);
        check("single_pb", 32'(pb_out), 32'h3c);
        check("single_hand", 32'(hand_out), 32'h0);
        check("single_busy", 32'(busy), 32'h1);
        repeat (63) step();
        check("single_pb_last", 32'(pb_out), 32'h3c);
        check("single_hand_last", 32'(hand_out), 32'h0);
        step();
        check("single_gap_pb", 32'(pb_out), 32'h3f);
        check("single_gap_hand", 32'(hand_out), 32'h1);
        check("single_gap_busy", 32'(busy), 32'h1);
        repeat (31) step();
        check("single_gap_end_busy", 32'(busy), 32'h1);
        step();
        check("single_idle_busy", 32'(busy), 32'h0);

        // Contention: pointer back to 0, all four valid
        reset = 1'b1;
        step();
        reset = 1'b0;
        rif.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            rif.req_cmd[7*i +: 7] = 7'(i + 1);
        end
        for (int n = 0; n < 5; n++) begin
            e = 3'(n % 4);
            #1;
            check("cont_ready", 32'(rif.req_ready), 32'(1 << e));
            step();
            check("cont_gid", 32'(grant_id), 32'(e));
            check("cont_pb", 32'(pb_out), 32'(6'h3f ^ 6'(e + 1)));
            check("cont_busy", 32'(busy), 32'h1);
            if (n == 4) begin
                rif.req_valid = '0;
            end
            repeat (95) step();
            check("cont_wait_ready", 32'(rif.req_ready), 32'h0);
            check("cont_wait_busy", 32'(busy), 32'h1);
            step();
        end

        // Pointer wrap: grant 3, then 1001 -> 0 then 3
        rif.req_valid = 4'b1000;
        rif.req_cmd[27:21] = 7'd4;
        #1;
        check("wrap_ready3", 32'(rif.req_ready), 32'h8);
        step();
        check("wrap_gid3", 32'(grant_id), 32'h3);
        rif.req_valid = '0;
        repeat (96) step();
        rif.req_valid = 4'b1001;
        rif.req_cmd[6:0] = 7'b1000011;
        #1;
        check("wrap_ready0", 32'(rif.req_ready), 32'h1);
        step();
        check("wrap_gid0", 32'(grant_id), 32'h0);
        check("wrap_pb0", 32'(pb_out), 32'h3c);
        repeat (96) step();
        check("wrap_ready3b", 32'(rif.req_ready), 32'h8);
        step();
        check("wrap_gid3b", 32'(grant_id), 32'h3);
        check("wrap_pb3b", 32'(pb_out), 32'h3b);
        rif.req_valid = '0;
        repeat (96) step();

        // No-op on requester 2
        rif.req_valid = 4'b0100;
        rif.req_cmd[20:14] = 7'd0;
        #1;
        check("noop_ready", 32'(rif.req_ready), 32'h4);
        step();
        check("noop_gid", 32'(grant_id), 32'h2);
        check("noop_pb", 32'(pb_out), 32'h3f);
        check("noop_hand", 32'(hand_out), 32'h1);
        check("noop_busy", 32'(busy), 32'h0);
        rif.req_valid = 4'b1011;
        #1;
        check("noop_next_ready", 32'(rif.req_ready), 32'h8);

        // Reset during ASSERT; grant 0 first so pointer moves to 1
        rif.req_valid = 4'b0001;
        #1;
        check("rmid_ready0", 32'(rif.req_ready), 32'h1);
        step();
        rif.req_valid = 4'b1001;
        repeat (19) step();
        check("rmid_pb_held", 32'(pb_out), 32'h3c);
        check("rmid_ready_busy", 32'(rif.req_ready), 32'h0);
        reset = 1'b1;
        step();
        check("rmid_pb", 32'(pb_out), 32'h3f);
        check("rmid_hand", 32'(hand_out), 32'h1);
        check("rmid_busy", 32'(busy), 32'h0);
        check("rmid_ready_rst", 32'(rif.req_ready), 32'h0);
        reset = 1'b0;
        #1;
        check("rmid_ready_ptr0", 32'(rif.req_ready), 32'h1);
        step();
        check("rmid_regrant", 32'(grant_id), 32'h0);
        check("rmid_regrant_pb", 32'(pb_out), 32'h3c);
        check("rmid_regrant_busy", 32'(busy), 32'h1);
        rif.req_valid = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/robotron_sound_cmd_sched.md
Name: robotron_sound_cmd_sched

Overview:
- Sound-command scheduler sitting in front of robotron_sound.
- Several game-side requesters (CPU PIA writes, attract-mode sequencer, test logic) submit 7-bit sound commands. The block arbitrates between them round-robin.
- It drives the active-low pb[5:0] and hand lines of the sound board with a fixed assert-hold, then a release gap, so the sound CPU reliably sees every edge.
- Runs on the CPU clock domain; pb_out and hand_out connect directly to robotron_sound .pb/.hand.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 64, clk cycles a command is held on pb/hand (>=1).
- GAP_CYCLES, 32, clk cycles of idle level (pb=6'b111111, hand=1) after each command (>=1).

Ports:
- clk  input  1  single system clock (CPU clock domain).
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester command valid.
- req_cmd  input  7*N_REQ  per-requester command, slice i = {hand_bit, code[5:0]}.
- req_ready  output  N_REQ  per-requester accept strobe (combinational, one-hot or zero).
- pb_out  output  6  to sound board, active low.
- hand_out  output  1  to sound board, active low.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  3  index of the last granted requester.

Behaviour:
- Reset (synchronous, active-high), applied at the next clk edge:
  - state=IDLE, pb_out=6'b111111, hand_out=1, busy=0, grant_id=0, rr pointer=0, counter=0.
  - Reset asserted mid-ASSERT or mid-GAP aborts the command; outputs return to idle level on that edge.
  - No request is accepted while reset is high.
- States: IDLE, ASSERT, GAP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping mod N_REQ.
  - req_ready[winner]=1 in the same cycle (combinational); all other ready bits 0. Ready is 0 in every non-IDLE state.
  - A handshake completes when valid & ready at a clk edge. Requesters hold valid/cmd stable until ready.
  - On accept: latch cmd, grant_id<=winner, ptr<=(winner+1) mod N_REQ.
  - Normal command: next state ASSERT; counter<=HOLD_CYCLES-1.
  - No-op command {hand_bit=0, code=0}: handshake still completes and ptr still advances, but the state stays IDLE and the outputs do not change.
- ASSERT:
  - pb_out = ~code; hand_out = ~hand_bit. Outputs are registered, so they change on the edge after the accept edge.
  - Counter decrements each cycle. At 0: next state GAP, counter<=GAP_CYCLES-1, and the outputs return to idle level on that edge.
  - Total hold = exactly HOLD_CYCLES cycles.
- GAP:
  - Outputs at idle level; counter decrements. At 0: next state IDLE.
  - Total gap = exactly GAP_CYCLES cycles.
  - Earliest next accept is the first IDLE cycle, so back-to-back commands are spaced exactly HOLD_CYCLES+GAP_CYCLES+1 cycles apart.
- busy=1 in ASSERT and GAP, 0 in IDLE.
- Counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES))+1, unsigned. No wrap: state exits on count 0.
- Simultaneous valids: exactly one grant per IDLE cycle. Unserved requesters keep waiting.
- Fairness: with all N_REQ valid continuously, every requester is granted once per N_REQ commands.
- A req_valid that drops before ready is simply not served; no state is retained.
- X/undefined req_cmd on non-granted slices has no effect.

Test Plan:
- Reset for 10 cycles, then observe: pb_out=6'b111111, hand_out=1, busy=0, req_ready=0 with no valid asserted.
- Single request, N_REQ=4, HOLD=64, GAP=32:
  - Stimulus: req_valid=4'b0001, cmd0=7'b1000011.
  - Required: ready[0] pulses 1 cycle; next edge pb_out=6'b111100, hand_out=0 for exactly 64 cycles; then 111111/1 for 32 cycles; busy high for 96 cycles total.
- Contention:
  - Stimulus: valid=4'b1111 held, distinct codes 1..4.
  - Required: grants in order 0,1,2,3,0; consecutive pb transitions exactly 97 cycles apart; grant_id tracks.
- Pointer wrap:
  - Stimulus: valid=4'b1001 after a grant to 3.
  - Required: next grant goes to 0, then 3.
- No-op: cmd=7'b0000000 on requester 2 -> ready[2] pulses; pb_out stays 111111; busy stays 0; next grant searches from 3.
- Reset at cycle 20 of ASSERT -> pb_out=111111 and hand_out=1 on that edge; busy=0; the pending requester is re-granted only after reset deasserts, starting from ptr=0.
